// File: rtl/u409_pkg.sv
// Shared definitions for the U409 bus cycle controller: FSM encoding,
// decoded-space identifiers, per-space wait counts and the timeout default.
package u409_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOCAL   = 3'd1,
    ST_EXTERN  = 3'd2,
    ST_ACK     = 3'd3,
    ST_TERR    = 3'd4,
    ST_RECOVER = 3'd5
  } state_t;

  // SP_NONE marks a cycle handed to the external responders.
  typedef enum logic [2:0] {
    SP_NONE = 3'd0,
    SP_AV   = 3'd1,
    SP_ROM  = 3'd2,
    SP_BREG = 3'd3,
    SP_RTC  = 3'd4,
    SP_ATA  = 3'd5
  } space_t;

  localparam logic [3:0] WAIT_AV   = 4'd1;
  localparam logic [3:0] WAIT_BREG = 4'd2;
  localparam logic [3:0] WAIT_ROM  = 4'd4;
  localparam logic [3:0] WAIT_RTC  = 4'd6;
  localparam logic [3:0] WAIT_ATA  = 4'd8;

  localparam int TIMEOUT_DEFAULT = 255;

  // Fixed priority among the local selects (all active-high here).
  function automatic space_t decode_space(input logic av, input logic rom,
                                          input logic breg, input logic rtc,
                                          input logic ata);
    if (av)        return SP_AV;
    else if (rom)  return SP_ROM;
    else if (breg) return SP_BREG;
    else if (rtc)  return SP_RTC;
    else if (ata)  return SP_ATA;
    else           return SP_NONE;
  endfunction

  function automatic logic [3:0] wait_for(input space_t sp);
    case (sp)
      SP_AV:   return WAIT_AV;
      SP_ROM:  return WAIT_ROM;
      SP_BREG: return WAIT_BREG;
      SP_RTC:  return WAIT_RTC;
      SP_ATA:  return WAIT_ATA;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/u409_wait_counter.sv
// Loadable down-counter for local device wait states. expire flags the
// cycle in which a decrement brings the count to zero.
module u409_wait_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       expire
);

  logic [3:0] count;

  // Load on cycle start, count down while the local access is in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  assign expire = dec && (count == 4'd1);

endmodule

// File: rtl/u409_cycle_control.sv
// U409 68040 bus cycle controller.
// Handshake: the CPU opens a cycle with a one-cycle TSn low pulse (sampled
// only in IDLE, together with RnW and the decoded selects). The cycle is
// closed by exactly one of: TAn low for one cycle (local or autovector),
// EXT_TAn from an external responder (no TAn from here), or TEAn low for one
// cycle on timeout. Every cycle ends with one RECOVER cycle before IDLE.
module u409_cycle_control
  import u409_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic   CLK40,
  input  logic   RESETn,
  input  logic   TSn,
  input  logic   RnW,
  input  logic   ROMEN,
  input  logic   CIA_SPACE,
  input  logic   AUTOVECTOR,
  input  logic   RTC_ENn,
  input  logic   ATA_ENn,
  input  logic   BREG_ENn,
  input  logic   EXT_TAn,
  output logic   TAn,
  output logic   TEAn,
  output logic   AVECn,
  output logic   DEV_OEn,
  output logic   DEV_WEn,
  output state_t dbg_state
);

  localparam logic [8:0] TIMEOUT_VAL = 9'(TIMEOUT);

  state_t     state, state_next;
  space_t     space_q;
  logic       rnw_q;
  logic [7:0] tmo_cnt;

  logic   accept;
  logic   go_extern;
  logic   busy;
  logic   wait_done;
  logic   tmo_hit;
  space_t space_dec;

  assign space_dec = decode_space(AUTOVECTOR, ROMEN, !BREG_ENn, !RTC_ENn, !ATA_ENn);
  assign accept    = (state == ST_IDLE) && !TSn;
  assign go_extern = CIA_SPACE || (space_dec == SP_NONE);
  assign busy      = (state == ST_LOCAL) || (state == ST_EXTERN);
  assign tmo_hit   = busy && (({1'b0, tmo_cnt} + 9'd1) == TIMEOUT_VAL);

  u409_wait_counter u_wait (
    .clk      (CLK40),
    .rst_n    (RESETn),
    .load     (accept && !go_extern),
    .load_val (wait_for(space_dec)),
    .dec      (state == ST_LOCAL),
    .expire   (wait_done)
  );

  // Latch the decoded space and direction on the TSn edge.
  always_ff @(posedge CLK40 or negedge RESETn) begin
    if (!RESETn) begin
      space_q <= SP_NONE;
      rnw_q   <= 1'b0;
    end else if (accept) begin
      space_q <= go_extern ? SP_NONE : space_dec;
      rnw_q   <= RnW;
    end
  end

  // Bus timeout counter, restarted at every accepted cycle.
  always_ff @(posedge CLK40 or negedge RESETn) begin
    if (!RESETn) begin
      tmo_cnt <= 8'd0;
    end else if (accept) begin
      tmo_cnt <= 8'd0;
    end else if (busy) begin
      tmo_cnt <= tmo_cnt + 8'd1;
    end
  end

  // State register.
  always_ff @(posedge CLK40 or negedge RESETn) begin
    if (!RESETn) state <= ST_IDLE;
    else         state <= state_next;
  end

  // Next-state logic; a normal acknowledge beats a coincident timeout.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) state_next = go_extern ? ST_EXTERN : ST_LOCAL;
      end
      ST_LOCAL: begin
        if (wait_done)    state_next = ST_ACK;
        else if (tmo_hit) state_next = ST_TERR;
      end
      ST_EXTERN: begin
        if (!EXT_TAn)     state_next = ST_RECOVER;
        else if (tmo_hit) state_next = ST_TERR;
      end
      ST_ACK:     state_next = ST_RECOVER;
      ST_TERR:    state_next = ST_RECOVER;
      ST_RECOVER: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from state and latched cycle attributes.
  always_comb begin
    TAn     = 1'b1;
    TEAn    = 1'b1;
    AVECn   = 1'b1;
    DEV_OEn = 1'b1;
    DEV_WEn = 1'b1;
    case (state)
      ST_LOCAL: begin
        if ((space_q != SP_AV) && (space_q != SP_NONE)) begin
          DEV_OEn = !rnw_q;
          DEV_WEn = rnw_q;
        end
      end
      ST_ACK: begin
        TAn   = 1'b0;
        AVECn = (space_q != SP_AV);
      end
      ST_TERR: TEAn = 1'b0;
      default: ;
    endcase
  end

  assign dbg_state = state;

endmodule
